calc_datapath_seq: RTL and testbench
====================================

Name: calc_datapath_seq

Overview:
Parametrised successor to the 4-bit/16-bit calculator datapath. Accepts multi-digit decimal entry into an entry register, applies an opcode against a WIDTH-bit accumulator, and supports iterative multiply and divide through a start/busy/done handshake. Status flags cover overflow and divide-by-zero, and a display mux selects entry or accumulator. Sits between the keypad controller FSM and the display driver.

Parameters:
WIDTH, 16, accumulator/entry/display width in bits (>=8)
DIGIT_W, 4, digit input width (BCD digit)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
digit_valid  in  1  one-cycle strobe: append digit to entry
digit  in  DIGIT_W  decimal digit 0-9
clear_entry  in  1  zero entry register
clear_all  in  1  zero entry, accumulator, flags; abort any operation
op_code  in  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 LOAD
op_start  in  1  one-cycle strobe: execute op_code (acc OP entry)
sel_display  in  1  0 = show entry, 1 = show accumulator
busy  out  1  operation in progress
done  out  1  one-cycle pulse: result written
ovf  out  1  overflow/borrow of last op or of entry
dbz  out  1  divide-by-zero on last op
disp_value  out  WIDTH  selected display value

Behaviour:
- Reset (rst_n=0, async): entry=0, acc=0, busy=0, done=0, ovf=0, dbz=0, FSM=IDLE; disp_value=0.
- FSM states: IDLE, EXEC, ITER, FIN.
  - IDLE + op_start -> EXEC; opcode latched.
  - EXEC: MUL/DIV with nonzero divisor -> ITER; otherwise compute and write acc -> FIN.
  - ITER: WIDTH cycles, one bit per cycle, then -> FIN.
  - FIN: done=1 for exactly one cycle, entry cleared to 0, -> IDLE.
- busy=1 in EXEC, ITER and FIN.
- Latency from op_start to done:
  - single-cycle ops (ADD, SUB, AND, OR, XOR, LOAD, DIV-by-0): done high on the 2nd rising edge after op_start.
  - MUL/DIV: done high on edge WIDTH+2.
- Arithmetic is unsigned; results are truncated to WIDTH bits.
  - ADD: ovf=carry out.
  - SUB: ovf=borrow (acc<entry).
  - MUL: shift-add; ovf=1 if any bit of the 2*WIDTH product above WIDTH-1 is set.
  - DIV: restoring; acc<=quotient; remainder discarded.
  - LOAD: acc<=entry.
- Divide by zero (entry==0 at EXEC): acc unchanged, dbz=1, ovf=0, proceeds directly to FIN.
- ovf and dbz are cleared at the EXEC of the next op, or by clear_all.
- Digit entry, accepted only when busy=0 and digit<=9:
  - entry <= entry*10+digit (mod 2^WIDTH).
  - ovf set if the true value exceeds 2^WIDTH-1.
  - digit>9 is ignored with no state change.
- Priority within a cycle: clear_all > clear_entry > op_start > digit_valid.
  - op_start and digit_valid together in IDLE: op runs on the old entry; digit dropped.
- op_start, digit_valid and clear_entry while busy: ignored.
- clear_all while busy: FSM -> IDLE next edge, acc=entry=0, flags=0, no done pulse.
- disp_value is combinational from registers: sel_display ? acc : entry. In ITER, acc holds its pre-op value; the partial result lives in internal registers.

Optional Feature:
CALC_SAT_EN:
- Defined: on ovf from ADD/MUL/digit entry, the affected register saturates to 2^WIDTH-1. On SUB borrow, acc saturates to 0. ovf is still flagged.
- Undefined: wrap-around (mod 2^WIDTH) as specified above.

Test Plan:
- Reset mid-MUL (rst_n low during ITER) -> immediate busy=0, acc=0, entry=0, done never pulses.
- Digits 1,2,3 then LOAD, digits 4,5, ADD -> done on the 2nd edge after op_start, acc=168, entry=0, ovf=0.
- acc=300, entry=250, MUL (WIDTH=16) -> done at edge 18, acc=75000 mod 65536=9464, ovf=1. With CALC_SAT_EN: acc=65535.
- acc=1000, entry=7, DIV -> acc=142, dbz=0. Then DIV with entry=0 -> acc stays 142, dbz=1, done after 2 edges.
- acc=5, entry=9, SUB -> acc=65532, ovf=1. With CALC_SAT_EN: acc=0. Then op_start during busy -> ignored, exactly one done pulse.
- Entry 6,5,5,3,6 -> entry=65536 mod 2^16=0, ovf=1. digit=12 -> ignored. clear_all during ITER -> acc=0, busy=0 next edge, no done.

Source files
------------

// File: rtl/calc_datapath_seq.sv
// Calculator datapath: decimal digit entry, WIDTH-bit accumulator, iterative MUL/DIV.
// Build option: define CALC_SAT_EN to saturate on overflow/borrow instead of wrapping.
module calc_datapath_seq #(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               clear_entry,
    input  logic               clear_all,
    input  logic [2:0]         op_code,
    input  logic               op_start,
    input  logic               sel_display,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic               dbz,
    output logic [WIDTH-1:0]   disp_value
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_FIN} state_t;
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV  = 3'd3,
        OP_AND  = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_LOAD = 3'd7
    } op_t;

`ifdef CALC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    state_t               r_state, w_state_next;
    op_t                  r_op;
    logic [WIDTH-1:0]     r_entry, r_acc;
    logic                 r_ovf, r_dbz;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_prod, r_mcand;
    logic [WIDTH-1:0]     r_mplier, r_rem, r_quot;

    logic                 w_entry_zero, w_iterative, w_last;
    logic [WIDTH+3:0]     w_entry_ext, w_entry_new;
    logic                 w_digit_ok, w_digit_ovf;
    logic [WIDTH-1:0]     w_digit_val;
    logic [WIDTH:0]       w_sum, w_diff;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_ovf;
    logic [2*WIDTH-1:0]   w_prod_next;
    logic                 w_mul_ovf;
    logic [WIDTH-1:0]     w_mul_res;
    logic [WIDTH:0]       w_rem_sh;
    logic                 w_rem_ge;
    logic [WIDTH-1:0]     w_rem_next, w_quot_next;

    assign w_entry_zero = (r_entry == '0);
    assign w_iterative  = (r_op == OP_MUL) || ((r_op == OP_DIV) && !w_entry_zero);
    assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));

    // entry*10 + digit, evaluated 4 bits wider so the true value is visible for overflow
    assign w_entry_ext = {4'b0000, r_entry};
    assign w_entry_new = (w_entry_ext << 3) + (w_entry_ext << 1) + (WIDTH+4)'(digit);
    assign w_digit_ok  = (digit <= DIGIT_W'(9));
    assign w_digit_ovf = |w_entry_new[WIDTH+3:WIDTH];
    assign w_digit_val = (SAT_EN && w_digit_ovf) ? ALL_ONES : w_entry_new[WIDTH-1:0];

    assign w_sum  = {1'b0, r_acc} + {1'b0, r_entry};
    assign w_diff = {1'b0, r_acc} - {1'b0, r_entry};

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_alu_res = r_acc;
        w_alu_ovf = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu_ovf = w_sum[WIDTH];
                w_alu_res = (SAT_EN && w_sum[WIDTH]) ? ALL_ONES : w_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                w_alu_ovf = w_diff[WIDTH];
                w_alu_res = (SAT_EN && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
            end
            OP_AND:  w_alu_res = r_acc & r_entry;
            OP_OR:   w_alu_res = r_acc | r_entry;
            OP_XOR:  w_alu_res = r_acc ^ r_entry;
            OP_LOAD: w_alu_res = r_entry;
            default: w_alu_res = r_acc;
        endcase
    end

    // One multiplier bit (shift-add) and one quotient bit (restoring) per ITER cycle
    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_mul_ovf   = |w_prod_next[2*WIDTH-1:WIDTH];
    assign w_mul_res   = (SAT_EN && w_mul_ovf) ? ALL_ONES : w_prod_next[WIDTH-1:0];

    assign w_rem_sh    = {r_rem, r_quot[WIDTH-1]};
    assign w_rem_ge    = (w_rem_sh >= {1'b0, r_entry});
    assign w_rem_next  = w_rem_ge ? WIDTH'(w_rem_sh - {1'b0, r_entry}) : w_rem_sh[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_rem_ge};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (op_start && !clear_entry) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = w_iterative ? S_ITER : S_FIN;
            S_ITER:  if (w_last) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (clear_all) w_state_next = S_IDLE;
    end

    // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: the iteration scratch registers are reset too, so nothing in the block powers up as X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_entry  <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
        end else if (clear_all) begin
            r_entry <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_entry) begin
                        r_entry <= '0;
                    end else if (op_start) begin
                        r_op <= op_t'(op_code);
                    end else if (digit_valid && w_digit_ok) begin
                        r_entry <= w_digit_val;
                        if (w_digit_ovf) r_ovf <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_ovf    <= 1'b0;
                    r_dbz    <= 1'b0;
                    r_cnt    <= '0;
                    r_prod   <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, r_acc};
                    r_mplier <= r_entry;
                    r_rem    <= '0;
                    r_quot   <= r_acc;
                    if (w_iterative) begin
                        r_ovf <= 1'b0;
                    end else if (r_op == OP_DIV) begin
                        r_dbz   <= 1'b1;
                        r_entry <= '0;
                    end else begin
                        r_acc   <= w_alu_res;
                        r_ovf   <= w_alu_ovf;
                        r_entry <= '0;
                    end
                end
                S_ITER: begin
                    r_cnt    <= r_cnt + 1'b1;
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_next;
                    r_quot   <= w_quot_next;
                    if (w_last) begin
                        r_acc   <= (r_op == OP_MUL) ? w_mul_res : w_quot_next;
                        r_ovf   <= (r_op == OP_MUL) && w_mul_ovf;
                        r_entry <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIN);
    assign ovf        = r_ovf;
    assign dbz        = r_dbz;
    assign disp_value = sel_display ? r_acc : r_entry;

endmodule

// File: tb/tb_calc_datapath_seq.sv
// Self-checking bench for calc_datapath_seq: vector table, hand-written corner sequences,
// and random operations against an arithmetic reference model (CALC_SAT_EN aware).
`timescale 1ns/1ps
module tb_calc_datapath_seq;

    localparam int     W    = 16;
    localparam longint MAXV = 65535;
    localparam longint MODV = 65536;
`ifdef CALC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
                           OP_AND = 3'd4, OP_OR = 3'd5, OP_XOR = 3'd6, OP_LOAD = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         digit_valid = 1'b0;
    logic [3:0]   digit = '0;
    logic         clear_entry = 1'b0;
    logic         clear_all = 1'b0;
    logic [2:0]   op_code = '0;
    logic         op_start = 1'b0;
    logic         sel_display = 1'b0;
    logic         busy, done, ovf, dbz;
    logic [W-1:0] disp_value;

    calc_datapath_seq #(.WIDTH(W), .DIGIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
        .clear_entry(clear_entry), .clear_all(clear_all), .op_code(op_code),
        .op_start(op_start), .sel_display(sel_display), .busy(busy), .done(done),
        .ovf(ovf), .dbz(dbz), .disp_value(disp_value)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        int unsigned a;
        int unsigned b;
        logic [2:0]  op;
        int unsigned exp_acc;
        bit          exp_ovf;
        bit          exp_dbz;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_disp(input bit sel, output longint v);
        sel_display = sel;
        #1;
        v = disp_value;
    endtask

    // Reference: plain unsigned arithmetic on the mathematical values
    function automatic void model(input longint a, input longint b, input logic [2:0] op,
                                  output longint r, output bit o, output bit z, output int lat);
        longint full;
        o = 1'b0; z = 1'b0; lat = 2; r = a;
        case (op)
            OP_ADD: begin
                full = a + b; o = (full > MAXV);
                r = !o ? full : (SAT ? MAXV : full - MODV);
            end
            OP_SUB: begin
                o = (a < b);
                r = !o ? a - b : (SAT ? 0 : a - b + MODV);
            end
            OP_MUL: begin
                full = a * b; o = (full > MAXV); lat = W + 2;
                r = !o ? full : (SAT ? MAXV : full % MODV);
            end
            OP_DIV: begin
                if (b == 0) z = 1'b1;
                else begin r = a / b; lat = W + 2; end
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = b;
        endcase
    endfunction

    task automatic enter_num(input int unsigned v);
        int digs[$];
        clear_entry = 1'b1;
        step();
        clear_entry = 1'b0;
        while (v > 0) begin
            digs.push_front(int'(v % 10));
            v = v / 10;
        end
        foreach (digs[i]) begin
            digit_valid = 1'b1;
            digit = 4'(digs[i]);
            step();
        end
        digit_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, output int lat);
        op_code  = op;
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic prepare(input int unsigned a, input int unsigned b);
        int lat;
        enter_num(a);
        run_op(OP_LOAD, lat);
        step();
        enter_num(b);
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input longint e_acc,
                         input bit e_ovf, input bit e_dbz, input int e_lat);
        int     lat;
        longint v;
        run_op(op, lat);
        check({name, ".latency"}, lat, e_lat);
        read_disp(1'b1, v);
        check({name, ".acc"}, v, e_acc);
        read_disp(1'b0, v);
        check({name, ".entry"}, v, 0);
        check({name, ".ovf"}, ovf, e_ovf);
        check({name, ".dbz"}, dbz, e_dbz);
        step();
        check({name, ".done_width"}, done, 0);
        check({name, ".idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        longint      v, r;
        bit          o, z;
        int          lat, ndone;
        int unsigned a, b;
        logic [2:0]  op;

        vecs.push_back('{"add_carry",   65535, 1,     OP_ADD,  SAT ? 65535 : 0,     1, 0, 2});
        vecs.push_back('{"add_plain",   100,   23,    OP_ADD,  123,                 0, 0, 2});
        vecs.push_back('{"sub_equal",   50,    50,    OP_SUB,  0,                   0, 0, 2});
        vecs.push_back('{"sub_borrow",  5,     9,     OP_SUB,  SAT ? 0 : 65532,     1, 0, 2});
        vecs.push_back('{"and",         61680, 65280, OP_AND,  61440,               0, 0, 2});
        vecs.push_back('{"or",          61680, 3855,  OP_OR,   65535,               0, 0, 2});
        vecs.push_back('{"xor",         65535, 255,   OP_XOR,  65280,               0, 0, 2});
        vecs.push_back('{"load",        7,     999,   OP_LOAD, 999,                 0, 0, 2});
        vecs.push_back('{"mul_fit",     255,   257,   OP_MUL,  65535,               0, 0, 18});
        vecs.push_back('{"mul_wrap",    256,   256,   OP_MUL,  SAT ? 65535 : 0,     1, 0, 18});
        vecs.push_back('{"mul_300x250", 300,   250,   OP_MUL,  SAT ? 65535 : 9464,  1, 0, 18});
        vecs.push_back('{"mul_zero",    1234,  0,     OP_MUL,  0,                   0, 0, 18});
        vecs.push_back('{"div_1000_7",  1000,  7,     OP_DIV,  142,                 0, 0, 18});
        vecs.push_back('{"div_by_one",  65535, 1,     OP_DIV,  65535,               0, 0, 18});
        vecs.push_back('{"div_small",   7,     9,     OP_DIV,  0,                   0, 0, 18});
        vecs.push_back('{"div_by_zero", 5,     0,     OP_DIV,  5,                   0, 1, 2});

        // Reset state
        #12;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.ovf", ovf, 0);
        check("reset.dbz", dbz, 0);
        read_disp(1'b0, v); check("reset.entry", v, 0);
        read_disp(1'b1, v); check("reset.acc", v, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Digits 1,2,3 LOAD; digits 4,5 ADD
        enter_num(123);
        read_disp(1'b0, v); check("seq168.entry123", v, 123);
        do_op("seq168.load", OP_LOAD, 123, 0, 0, 2);
        enter_num(45);
        read_disp(1'b0, v); check("seq168.entry45", v, 45);
        do_op("seq168.add", OP_ADD, 168, 0, 0, 2);

        foreach (vecs[i]) begin
            prepare(vecs[i].a, vecs[i].b);
            do_op(vecs[i].name, vecs[i].op, vecs[i].exp_acc, vecs[i].exp_ovf,
                  vecs[i].exp_dbz, vecs[i].exp_lat);
        end

        // DIV then DIV by zero keeps the quotient; next op clears dbz
        prepare(1000, 7);
        do_op("div_seq.q", OP_DIV, 142, 0, 0, 18);
        enter_num(0);
        do_op("div_seq.zero", OP_DIV, 142, 0, 1, 2);
        enter_num(1);
        do_op("div_seq.clear_dbz", OP_ADD, 143, 0, 0, 2);

        // SUB borrow with op_start held while busy: exactly one done
        prepare(5, 9);
        op_code  = OP_SUB;
        op_start = 1'b1;
        ndone    = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 2) op_start = 1'b0;
            if (done) ndone++;
        end
        check("busy_ignore.done_count", ndone, 1);
        check("busy_ignore.idle", busy, 0);
        check("busy_ignore.ovf", ovf, 1);
        read_disp(1'b1, v); check("busy_ignore.acc", v, SAT ? 0 : 65532);

        // op_start and digit together: op uses old entry, digit dropped
        prepare(10, 5);
        op_code     = OP_ADD;
        op_start    = 1'b1;
        digit_valid = 1'b1;
        digit       = 4'd7;
        step();
        op_start    = 1'b0;
        digit_valid = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin step(); lat++; end
        check("start_and_digit.latency", lat, 2);
        read_disp(1'b1, v); check("start_and_digit.acc", v, 15);
        step();

        // Entry overflow 65536, then digit>9 ignored and digit 9 accepted
        enter_num(65536);
        read_disp(1'b0, v); check("entry_ovf.entry", v, SAT ? 65535 : 0);
        check("entry_ovf.ovf", ovf, 1);
        enter_num(4);
        digit_valid = 1'b1; digit = 4'd12; step();
        digit_valid = 1'b0;
        read_disp(1'b0, v); check("digit12.ignored", v, 4);
        digit_valid = 1'b1; digit = 4'd9; step();
        digit_valid = 1'b0;
        read_disp(1'b0, v); check("digit9.accepted", v, 49);

        // clear_all during ITER
        prepare(300, 250);
        op_code = OP_MUL; op_start = 1'b1; step(); op_start = 1'b0;
        repeat (5) step();
        check("clear_all.busy_before", busy, 1);
        clear_all = 1'b1; step(); clear_all = 1'b0;
        check("clear_all.busy", busy, 0);
        check("clear_all.ovf", ovf, 0);
        check("clear_all.dbz", dbz, 0);
        read_disp(1'b1, v); check("clear_all.acc", v, 0);
        read_disp(1'b0, v); check("clear_all.entry", v, 0);
        ndone = 0;
        repeat (25) begin step(); if (done) ndone++; end
        check("clear_all.no_done", ndone, 0);

        // Asynchronous reset mid-MUL
        prepare(300, 250);
        op_code = OP_MUL; op_start = 1'b1; step(); op_start = 1'b0;
        repeat (6) step();
        check("reset_mid.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid.busy", busy, 0);
        check("reset_mid.done", done, 0);
        read_disp(1'b1, v); check("reset_mid.acc", v, 0);
        read_disp(1'b0, v); check("reset_mid.entry", v, 0);
        ndone = 0;
        repeat (2) begin step(); if (done) ndone++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin step(); if (done) ndone++; end
        check("reset_mid.no_done", ndone, 0);

        // Random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            a  = $urandom_range(0, 65535);
            case ($urandom_range(0, 3))
                0:       b = 0;
                1:       b = $urandom_range(1, 300);
                default: b = $urandom_range(0, 65535);
            endcase
            op = 3'($urandom_range(0, 7));
            model(a, b, op, r, o, z, lat);
            prepare(a, b);
            do_op($sformatf("rand%0d_op%0d_%0d_%0d", i, op, a, b), op, r, o, z, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
